keypad_scan_ctrl: RTL

Scan controller for the 4x4 matrix keypad that feeds the button/LED/buzzer demo. It drives the column lines in sequence, samples and debounces the row lines, and reports one event per accepted key press. It holds the last accepted key code on the LEDs and sequences a fixed-length buzzer beep per accepted press. It sits between the keypad pins and any downstream logic that consumes key events.

---
 rtl/keypad_pkg.sv | 46 ++++
 rtl/keypad_col_scanner.sv | 68 ++++++
 rtl/keypad_scan_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared constants, FSM state type and frame helpers for the 4x4 keypad scanner.
package keypad_pkg;

   localparam int KEY_W    = 4;
   localparam int FRAME_W  = 16;
   localparam int NUM_COLS = 4;
   localparam int NUM_ROWS = 4;

   localparam logic [NUM_COLS-1:0] COL0 = 4'b1110;
   localparam logic [NUM_COLS-1:0] COL1 = 4'b1101;
   localparam logic [NUM_COLS-1:0] COL2 = 4'b1011;
   localparam logic [NUM_COLS-1:0] COL3 = 4'b0111;

   typedef enum logic {
      IDLE = 1'b0,
      HELD = 1'b1
   } scan_state_t;

   function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] idx);
      logic [NUM_COLS-1:0] drv;
      case (idx)
         2'd0:    drv = COL0;
         2'd1:    drv = COL1;
         2'd2:    drv = COL2;
         default: drv = COL3;
      endcase
      return drv;
   endfunction

   // Only meaningful when exactly one bit is set.
   function automatic logic [KEY_W-1:0] onehot_to_idx(input logic [FRAME_W-1:0] v);
      logic [KEY_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < FRAME_W; i++) begin
         if (v[i]) begin
            idx = idx | KEY_W'(i);
         end
      end
      return idx;
   endfunction

   function automatic logic is_single_key(input logic [FRAME_W-1:0] v);
      return (v != '0) && ((v & (v - FRAME_W'(1))) == '0);
   endfunction

endpackage

// File: rtl/keypad_col_scanner.sv
// Column sequencer: drives one column low at a time, samples the synchronized
// rows at the end of each dwell and assembles a 16-bit pressed-key frame.
module keypad_col_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV = 50000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [3:0]         row_sync,
   output logic [3:0]         col,
   output logic [FRAME_W-1:0] frame,
   output logic               frame_done
);

   localparam int DIV_W = $clog2(SCAN_DIV);

   logic [DIV_W-1:0]   dwell_reg;
   logic [1:0]         col_idx_reg;
   logic [3:0]         col_reg;
   logic [FRAME_W-1:0] acc_reg;
   logic [FRAME_W-1:0] acc_next;
   logic [FRAME_W-1:0] frame_reg;
   logic               frame_done_reg;
   logic               sample;

   assign sample = (dwell_reg == DIV_W'(SCAN_DIV - 1));

   // Each column's nibble is overwritten once per frame, so no clearing is needed.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_COLS; gi++) begin : g_col
         assign acc_next[gi*NUM_ROWS +: NUM_ROWS] =
            (sample && (col_idx_reg == 2'(gi))) ? ~row_sync
                                                : acc_reg[gi*NUM_ROWS +: NUM_ROWS];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dwell_reg      <= '0;
         col_idx_reg    <= 2'd0;
         col_reg        <= COL0;
         acc_reg        <= '0;
         frame_reg      <= '0;
         frame_done_reg <= 1'b0;
      end else begin
         acc_reg        <= acc_next;
         frame_done_reg <= 1'b0;
         if (sample) begin
            dwell_reg   <= '0;
            col_idx_reg <= col_idx_reg + 2'd1;
            col_reg     <= col_drive(col_idx_reg + 2'd1);
            if (col_idx_reg == 2'd3) begin
               frame_reg      <= acc_next;
               frame_done_reg <= 1'b1;
            end
         end else begin
            dwell_reg <= dwell_reg + DIV_W'(1);
         end
      end
   end

   assign col        = col_reg;
   assign frame      = frame_reg;
   assign frame_done = frame_done_reg;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scan controller: row synchronizer, frame debounce, press/release
// FSM emitting one key event per accepted press, and a fixed-length beep.
module keypad_scan_ctrl
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int BEEP_CYCLES    = 5000000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       row,
   output logic [3:0]       col,
   output logic [KEY_W-1:0] key_code,
   output logic             key_valid,
   output logic             key_held,
   output logic             buzzer,
   output logic [7:0]       led
);

   localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
   localparam int BEEP_W = $clog2(BEEP_CYCLES + 1);

   logic [3:0]         row_meta_reg;
   logic [3:0]         row_sync_reg;
   logic [FRAME_W-1:0] frame;
   logic               frame_done;

   logic [CNT_W-1:0]   stable_cnt_reg;
   logic [CNT_W-1:0]   stable_cnt_next;
   logic [FRAME_W-1:0] prev_frame_reg;
   logic               frame_stable;
   logic               accept;
   logic               key_release;

   scan_state_t        state_reg;
   logic [KEY_W-1:0]   key_code_reg;
   logic               key_valid_reg;
   logic               key_held_reg;

   logic [BEEP_W-1:0]  beep_cnt_reg;
   logic [BEEP_W-1:0]  beep_cnt_next;
   logic               buzzer_reg;

   // Rows idle high, so the synchronizer resets to "no key".
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_meta_reg <= 4'hF;
         row_sync_reg <= 4'hF;
      end else begin
         row_meta_reg <= row;
         row_sync_reg <= row_meta_reg;
      end
   end

   keypad_col_scanner #(
      .SCAN_DIV (SCAN_DIV)
   ) u_scanner (
      .clk        (clk),
      .rst_n      (rst_n),
      .row_sync   (row_sync_reg),
      .col        (col),
      .frame      (frame),
      .frame_done (frame_done)
   );

   always_comb begin
      stable_cnt_next = CNT_W'(1);
      if (frame == prev_frame_reg) begin
         stable_cnt_next = (stable_cnt_reg == CNT_W'(DEBOUNCE_SCANS))
                           ? stable_cnt_reg : stable_cnt_reg + CNT_W'(1);
      end
   end

   assign frame_stable = (stable_cnt_next == CNT_W'(DEBOUNCE_SCANS));
   assign accept       = frame_done && (state_reg == IDLE) && frame_stable && is_single_key(frame);
   assign key_release  = frame_done && (state_reg == HELD) && frame_stable && (frame == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable_cnt_reg <= '0;
         prev_frame_reg <= '0;
      end else if (frame_done) begin
         stable_cnt_reg <= stable_cnt_next;
         prev_frame_reg <= frame;
      end
   end

   // A new press is only honoured from IDLE, i.e. after a stable release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         key_code_reg  <= '0;
         key_valid_reg <= 1'b0;
         key_held_reg  <= 1'b0;
      end else begin
         key_valid_reg <= accept;
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  key_code_reg <= onehot_to_idx(frame);
                  key_held_reg <= 1'b1;
                  state_reg    <= HELD;
               end
            end
            HELD: begin
               if (key_release) begin
                  key_held_reg <= 1'b0;
                  state_reg    <= IDLE;
               end
            end
            default: begin
               key_held_reg <= 1'b0;
               state_reg    <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      beep_cnt_next = beep_cnt_reg;
      if (accept) begin
         beep_cnt_next = BEEP_W'(BEEP_CYCLES);
      end else if (beep_cnt_reg != '0) begin
         beep_cnt_next = beep_cnt_reg - BEEP_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beep_cnt_reg <= '0;
         buzzer_reg   <= 1'b0;
      end else begin
         beep_cnt_reg <= beep_cnt_next;
         buzzer_reg   <= (beep_cnt_next != '0);
      end
   end

   assign key_code  = key_code_reg;
   assign key_valid = key_valid_reg;
   assign key_held  = key_held_reg;
   assign buzzer    = buzzer_reg;
   assign led       = {key_held_reg, 3'b000, key_code_reg};

endmodule
